vx_commit_gather: RTL

- Receive-side counterpart of a lane-serialised functional unit such as the dot8 ALU.
- The unit emits one warp result as several commit fragments of NUM_LANES lanes each. Each fragment carries a pid, and sop/eop flags mark the first and last fragment.
- This block reassembles the fragments into a single full-warp (NUM_THREADS) writeback packet.
- It sits between the functional-unit commit output and the commit arbiter.

---
 rtl/vx_commit_gather_pkg.sv | 32 +++
 rtl/vx_gather_buf.sv | 62 ++++++
 rtl/vx_commit_gather.sv | 137 +++++++++++++
 3 files changed

// File: rtl/vx_commit_gather_pkg.sv
// Shared types and sizing helpers for the commit fragment gatherer.
//   state_e      : gather FSM state
//   commit_tag_t : {uuid, wid, PC, rd, wb} writeback metadata, 64 bits
//   pid_count()  : fragments per warp
//   pid_width()  : width of the fragment index (at least 1)
package vx_commit_gather_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } state_e;

  typedef struct packed {
    logic [19:0] uuid;
    logic [5:0]  wid;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        wb;
  } commit_tag_t;

  localparam int unsigned COMMIT_TAG_W = $bits(commit_tag_t);

  function automatic int unsigned pid_count(input int unsigned nt, input int unsigned nl);
    return nt / nl;
  endfunction

  function automatic int unsigned pid_width(input int unsigned nt, input int unsigned nl);
    return (nt / nl > 1) ? $clog2(nt / nl) : 1;
  endfunction

endpackage

// File: rtl/vx_gather_buf.sv
// Slot-addressed register bank holding one warp of lane results and mask.
//   wr_en     : write the fragment into slot wr_pid
//   wr_clr    : also clear every mask bit outside the written slot
//   wr_data   : NUM_LANES*XLEN lane results, lane 0 in the LSBs
//   wr_tmask  : NUM_LANES lane mask
//   buf_data  : NUM_THREADS*XLEN assembled results
//   buf_tmask : NUM_THREADS assembled mask
module vx_gather_buf
  import vx_commit_gather_pkg::*;
#(
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned NUM_LANES   = 2,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned PID_WIDTH   = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [PID_WIDTH-1:0]        wr_pid,
  input  logic                        wr_clr,
  input  logic [NUM_LANES*XLEN-1:0]   wr_data,
  input  logic [NUM_LANES-1:0]        wr_tmask,
  output logic [NUM_THREADS*XLEN-1:0] buf_data,
  output logic [NUM_THREADS-1:0]      buf_tmask
);

  localparam int unsigned PID_COUNT = pid_count(NUM_THREADS, NUM_LANES);
  localparam int unsigned FRAG_W    = NUM_LANES * XLEN;

  logic [NUM_THREADS*XLEN-1:0] data_q, data_d;
  logic [NUM_THREADS-1:0]      tmask_q, tmask_d;

  // Clear-then-write leaves only the addressed slot's mask populated on sop.
  // A pid beyond PID_COUNT matches no slot and writes nothing.
  always_comb begin
    data_d  = data_q;
    tmask_d = tmask_q;
    if (wr_en) begin
      if (wr_clr) tmask_d = '0;
      for (int unsigned p = 0; p < PID_COUNT; p++) begin
        if (wr_pid == PID_WIDTH'(p)) begin
          data_d[p*FRAG_W +: FRAG_W]        = wr_data;
          tmask_d[p*NUM_LANES +: NUM_LANES] = wr_tmask;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      tmask_q <= '0;
    end else begin
      data_q  <= data_d;
      tmask_q <= tmask_d;
    end
  end

  assign buf_data  = data_q;
  assign buf_tmask = tmask_q;

endmodule

// File: rtl/vx_commit_gather.sv
// Reassembles lane-serialised commit fragments into one full-warp packet.
//   in_*      : fragment stream (valid/ready, data, tmask, pid, sop, eop, tag)
//   out_*     : assembled warp (valid/ready, data, tmask, tag from sop)
//   err_seq   : one-cycle pulse after a fragment that breaks sequencing
module vx_commit_gather
  import vx_commit_gather_pkg::*;
#(
  parameter  int unsigned NUM_THREADS = 4,
  parameter  int unsigned NUM_LANES   = 2,
  parameter  int unsigned XLEN        = 32,
  parameter  int unsigned TAG_WIDTH   = 64,
  localparam int unsigned PID_WIDTH   = pid_width(NUM_THREADS, NUM_LANES)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_LANES*XLEN-1:0]   in_data,
  input  logic [NUM_LANES-1:0]        in_tmask,
  input  logic [PID_WIDTH-1:0]        in_pid,
  input  logic                        in_sop,
  input  logic                        in_eop,
  input  logic [TAG_WIDTH-1:0]        in_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_THREADS*XLEN-1:0] out_data,
  output logic [NUM_THREADS-1:0]      out_tmask,
  output logic [TAG_WIDTH-1:0]        out_tag,
  output logic                        err_seq
);

  state_e                 state_q, state_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic                   accept;
  logic                   buf_we;

  // Next state, tag latch, buffer write enable and error pulse.
  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    err_d    = 1'b0;
    buf_we   = 1'b0;
    in_ready = 1'b0;

    unique case (state_q)
      IDLE:    in_ready = reset;
      COLLECT: in_ready = reset;
      FULL:    in_ready = reset & out_ready;
      default: in_ready = 1'b0;
    endcase
    accept = in_valid & in_ready;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_sop) begin
            buf_we  = 1'b1;
            tag_d   = in_tag;
            state_d = in_eop ? FULL : COLLECT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (accept) begin
          buf_we = 1'b1;
          if (in_sop) begin
            // Restart: a new sop discards the partial warp.
            tag_d   = in_tag;
            err_d   = 1'b1;
            state_d = in_eop ? FULL : COLLECT;
          end else begin
            if (in_tag != tag_q) err_d = 1'b1;
            if (in_eop) state_d = FULL;
          end
        end
      end
      FULL: begin
        // Any accept here coincides with the output handshake.
        if (out_ready) begin
          state_d = IDLE;
          if (accept) begin
            if (in_sop) begin
              buf_we  = 1'b1;
              tag_d   = in_tag;
              state_d = in_eop ? FULL : COLLECT;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == FULL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tag_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  vx_gather_buf #(
    .NUM_THREADS (NUM_THREADS),
    .NUM_LANES   (NUM_LANES),
    .XLEN        (XLEN),
    .PID_WIDTH   (PID_WIDTH)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (buf_we),
    .wr_pid    (in_pid),
    .wr_clr    (in_sop),
    .wr_data   (in_data),
    .wr_tmask  (in_tmask),
    .buf_data  (out_data),
    .buf_tmask (out_tmask)
  );

  assign out_valid = valid_q;
  assign out_tag   = tag_q;
  assign err_seq   = err_q;

endmodule
